// File: rtl/piano_voice_sched.sv
// Time-multiplexed voice scheduler: one shared ROM port and one accumulator serve all eight keys.
// Optional per-frame normalisation by active-key count is built when PIANO_SCHED_NORM_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | wait for tick count 0 (T0); snapshot keys, clear acc
// S_ISSUE  | one cycle per key k=0..7; ROM strobe visible for key k
// S_DRAIN  | last ROM sample (key 7) is accumulated
// S_MIX    | acc final; mix/saturate and register the output sample
// S_OUT    | wave_valid high with the new wave; back to idle
module piano_voice_sched #(
   parameter int TICK_DIV = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] keys,
   input  logic       cfg_we,
   input  logic [2:0] cfg_idx,
   input  logic [7:0] cfg_inc,
   output logic       rom_en,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic [7:0] wave,
   output logic       wave_valid
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_MIX   = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   localparam logic [7:0] INC_RST [0:7] = '{8'd16, 8'd18, 8'd20, 8'd21,
                                            8'd24, 8'd27, 8'd30, 8'd32};

   logic [2:0]         state;
   logic [CW-1:0]      tick_cnt;
   logic [2:0]         key_idx;
   logic [2:0]         key_nxt;
   logic [7:0]         snap;
   logic [7:0]         phase [0:7];
   logic [7:0]         inc   [0:7];
   logic signed [10:0] acc;
   logic signed [10:0] sample_ext;
   logic signed [10:0] mix_val;
   logic [7:0]         sat_val;
   logic               rom_en_d;
   logic               t0;
   logic               issue_last;

   assign t0         = (state == S_IDLE) && (tick_cnt == '0);
   assign key_nxt    = key_idx + 3'd1;
   assign issue_last = (state == S_ISSUE) && (key_idx == 3'd7);

   // offset-binary to two's complement, then sign-extend
   assign sample_ext = signed'({{3{~rom_data[7]}}, ~rom_data[7], rom_data[6:0]});

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         key_idx <= 3'd0;
         snap    <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (t0) begin
                  snap    <= keys;
                  key_idx <= 3'd0;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (key_idx == 3'd7) begin
                  state <= S_DRAIN;
               end else begin
                  key_idx <= key_nxt;
               end
            end
            S_DRAIN: state <= S_MIX;
            S_MIX:   state <= S_OUT;
            S_OUT:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            inc[i] <= INC_RST[i];
         end
      end else if (cfg_we) begin
         inc[cfg_idx] <= cfg_inc;
      end
   end

   // released keys restart from phase 0 on their next press
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            phase[i] <= 8'd0;
         end
      end else if (t0) begin
         for (int i = 0; i < 8; i++) begin
            if (!keys[i]) begin
               phase[i] <= 8'd0;
            end
         end
      end else if ((state == S_ISSUE) && snap[key_idx]) begin
         phase[key_idx] <= phase[key_idx] + inc[key_idx];
      end
   end

   // rom_en/rom_addr are registered so they are valid during the ISSUE cycle of their key
   always_ff @(posedge clk) begin
      if (rst) begin
         rom_en   <= 1'b0;
         rom_addr <= 8'd0;
         rom_en_d <= 1'b0;
      end else begin
         rom_en_d <= rom_en;
         if (t0) begin
            rom_en <= keys[0];
            if (keys[0]) begin
               rom_addr <= phase[0];
            end
         end else if ((state == S_ISSUE) && !issue_last) begin
            rom_en <= snap[key_nxt];
            if (snap[key_nxt]) begin
               rom_addr <= phase[key_nxt];
            end
         end else begin
            rom_en <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (t0) begin
         acc <= '0;
      end else if (rom_en_d) begin
         acc <= acc + sample_ext;
      end
   end

`ifdef PIANO_SCHED_NORM_EN
   logic [3:0] n_keys;

   always_ff @(posedge clk) begin
      if (rst) begin
         n_keys <= 4'd0;
      end else if (t0) begin
         n_keys <= 4'd0;
      end else if ((state == S_ISSUE) && snap[key_idx]) begin
         n_keys <= n_keys + 4'd1;
      end
   end

   always_comb begin
      mix_val = acc;
      case (n_keys)
         4'd0, 4'd1: mix_val = acc;
         4'd2:       mix_val = acc >>> 1;
         4'd3, 4'd4: mix_val = acc >>> 2;
         default:    mix_val = acc >>> 3;
      endcase
   end
`else
   always_comb begin
      mix_val = acc;
   end
`endif

   always_comb begin
      sat_val = mix_val[7:0];
      if (mix_val > 11'sd127) begin
         sat_val = 8'h7F;
      end else if (mix_val < -11'sd128) begin
         sat_val = 8'h80;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wave       <= 8'd128;
         wave_valid <= 1'b0;
      end else begin
         wave_valid <= 1'b0;
         if (state == S_MIX) begin
            wave       <= {~sat_val[7], sat_val[6:0]};
            wave_valid <= 1'b1;
         end
      end
   end

endmodule
